// File: rtl/seg_display_sched.sv
// seg_display_sched
//   Drives four active-low 7-segment digits. The block has three modes:
//   - IDLE: all digits are blank.
//   - ANIM: a single lit segment runs around the outer edge of the four
//     digits, one frame per animation step, in 12 frames.
//   - SHOW: a captured 16-bit value is shown as four hex digits for
//     HOLD_STEPS step periods.
//
// Parameters
//   PRESCALE   : clk cycles per animation step (>= 2)
//   HOLD_STEPS : step periods a captured value stays displayed (>= 1)
//
// Ports
//   clk           : sole clock, rising edge
//   rst           : asynchronous active-high reset
//   anim_en       : level, run the perimeter animation
//   val_req       : level, request display of val_data (held until val_ack)
//   val_data      : four hex digits, [15:12] -> disp_3 ... [3:0] -> disp_0
//   val_ack       : one-cycle pulse, the cycle after a request is accepted
//   step_tick     : one-cycle pulse per animation step (ANIM only)
//   frame_idx     : current animation frame 0..11, frozen during SHOW
//   busy          : high while SHOW is active
//   disp_0..disp_3: active-low segments, index 0..6 = a..g
//
// Configuration macro
//   SEG_BLANK_LEADING_ZERO_EN : when defined, leading zero digits are blanked
//                               in SHOW (disp_0 is always shown).
module seg_display_sched #(
  parameter int PRESCALE   = 4,
  parameter int HOLD_STEPS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        anim_en,
  input  logic        val_req,
  input  logic [15:0] val_data,
  output logic        val_ack,
  output logic        step_tick,
  output logic [3:0]  frame_idx,
  output logic        busy,
  output logic [0:6]  disp_0,
  output logic [0:6]  disp_1,
  output logic [0:6]  disp_2,
  output logic [0:6]  disp_3
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS + 1) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [HW-1:0] HOLD_INIT  = HW'(HOLD_STEPS);
  localparam logic [0:6]    BLANK      = 7'b1111111;

  typedef enum logic [1:0] {IDLE, ANIM, SHOW} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    frame_q, frame_d;
  logic [15:0]   val_q, val_d;
  logic          ack_q, ack_d;
  logic          presc_wrap;
  logic          tick;

  // Standard active-low hex font, segments listed a..g.
  function automatic logic [0:6] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b0000001;
      4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;
      4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;
      4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;
      4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;
      4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  assign presc_wrap = (presc_q == PRESC_LAST);
  assign tick       = (state_q == ANIM) && presc_wrap;

  // Next-state logic. A request wins over anim_en in both IDLE and ANIM.
  // A step tick coinciding with leaving ANIM still advances the frame,
  // except that dropping back to IDLE always returns the frame to 0.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    hold_d  = hold_q;
    frame_d = frame_q;
    val_d   = val_q;
    ack_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (val_req) begin
          state_d = SHOW;
          val_d   = val_data;
          hold_d  = HOLD_INIT;
          ack_d   = 1'b1;
          presc_d = '0;
        end else if (anim_en) begin
          state_d = ANIM;
          presc_d = '0;
        end
      end
      ANIM: begin
        if (tick) frame_d = (frame_q == 4'd11) ? 4'd0 : frame_q + 4'd1;
        if (val_req) begin
          state_d = SHOW;
          val_d   = val_data;
          hold_d  = HOLD_INIT;
          ack_d   = 1'b1;
          presc_d = '0;
        end else if (!anim_en) begin
          state_d = IDLE;
          presc_d = '0;
          frame_d = 4'd0;
        end else begin
          presc_d = presc_wrap ? '0 : presc_q + PW'(1);
        end
      end
      SHOW: begin
        // The final prescaler wrap takes the hold count to zero, so the
        // exit happens on that same edge rather than one cycle later.
        if (presc_wrap) begin
          presc_d = '0;
          if (hold_q <= HW'(1)) begin
            hold_d  = '0;
            state_d = anim_en ? ANIM : IDLE;
          end else begin
            hold_d = hold_q - HW'(1);
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        presc_d = '0;
        hold_d  = '0;
      end
    endcase
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      hold_q  <= '0;
      frame_q <= 4'd0;
      val_q   <= 16'h0000;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      hold_q  <= hold_d;
      frame_q <= frame_d;
      val_q   <= val_d;
      ack_q   <= ack_d;
    end
  end

  assign val_ack   = ack_q;
  assign step_tick = tick;
  assign frame_idx = frame_q;
  assign busy      = (state_q == SHOW);

  // Segment decode from registered state only: the perimeter frame in
  // ANIM, the captured value in SHOW, blank otherwise.
  always_comb begin
    logic blank3, blank2, blank1;
    disp_0 = BLANK;
    disp_1 = BLANK;
    disp_2 = BLANK;
    disp_3 = BLANK;
`ifdef SEG_BLANK_LEADING_ZERO_EN
    blank3 = (val_q[15:12] == 4'h0);
    blank2 = (val_q[15:8] == 8'h00);
    blank1 = (val_q[15:4] == 12'h000);
`else
    blank3 = 1'b0;
    blank2 = 1'b0;
    blank1 = 1'b0;
`endif
    case (state_q)
      ANIM: begin
        case (frame_q)
          4'd0:  disp_0 = 7'b0111111;
          4'd1:  disp_1 = 7'b0111111;
          4'd2:  disp_2 = 7'b0111111;
          4'd3:  disp_3 = 7'b0111111;
          4'd4:  disp_3 = 7'b1011111;
          4'd5:  disp_3 = 7'b1101111;
          4'd6:  disp_3 = 7'b1110111;
          4'd7:  disp_2 = 7'b1110111;
          4'd8:  disp_1 = 7'b1110111;
          4'd9:  disp_0 = 7'b1110111;
          4'd10: disp_0 = 7'b1111011;
          4'd11: disp_0 = 7'b1111101;
          default: disp_0 = BLANK;
        endcase
      end
      SHOW: begin
        disp_0 = hex7(val_q[3:0]);
        disp_1 = blank1 ? BLANK : hex7(val_q[7:4]);
        disp_2 = blank2 ? BLANK : hex7(val_q[11:8]);
        disp_3 = blank3 ? BLANK : hex7(val_q[15:12]);
      end
      default: disp_0 = BLANK;
    endcase
  end

endmodule

// File: tb/tb_seg_display_sched.sv
// tb_seg_display_sched
//   Randomised bench for seg_display_sched (PRESCALE=4, HOLD_STEPS=2).
//   A reference model written in terms of time spent in each mode
//   predicts every cycle's outputs; accepted requests are queued and a
//   separate monitor checks the shown digits whenever val_ack pulses.
module tb_seg_display_sched;

  localparam int P = 4;
  localparam int H = 2;
  localparam int NCYC = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        anim_en;
  logic        val_req;
  logic [15:0] val_data;
  logic        val_ack;
  logic        step_tick;
  logic [3:0]  frame_idx;
  logic        busy;
  logic [0:6]  disp_0, disp_1, disp_2, disp_3;

  int n_compared = 0;
  int n_mismatched = 0;

  // Reference model: mode 0 = blank, 1 = animating, 2 = showing a value.
  int          m_mode, m_phase, m_frame, m_left;
  logic [15:0] m_shown;
  bit          m_ack;
  logic [15:0] sb_q[$];

  bit          req_pending;
  int          n_req = 0;
  bit          did_reset = 0;

  int          frame_digit [12] = '{0, 1, 2, 3, 3, 3, 3, 2, 1, 0, 0, 0};
  int          frame_seg   [12] = '{0, 0, 0, 0, 1, 2, 3, 3, 3, 3, 4, 5};
  logic [6:0]  hex_font    [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  seg_display_sched #(.PRESCALE(P), .HOLD_STEPS(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .anim_en   (anim_en),
    .val_req   (val_req),
    .val_data  (val_data),
    .val_ack   (val_ack),
    .step_tick (step_tick),
    .frame_idx (frame_idx),
    .busy      (busy),
    .disp_0    (disp_0),
    .disp_1    (disp_1),
    .disp_2    (disp_2),
    .disp_3    (disp_3)
  );

  always #5 clk = ~clk;

  // 28-bit image {disp_3, disp_2, disp_1, disp_0}, segment a at the top of each digit.
  function automatic logic [27:0] anim_pattern(input int f);
    int pos;
    pos = 7 * frame_digit[f] + 6 - frame_seg[f];
    return ~(28'h1 << pos);
  endfunction

  function automatic logic [27:0] show_pattern(input logic [15:0] v);
    logic [27:0] res;
    logic [6:0]  code;
    res = '0;
    for (int k = 0; k < 4; k++) begin
      code = hex_font[(v >> (4 * k)) & 16'hF];
`ifdef SEG_BLANK_LEADING_ZERO_EN
      if (k > 0 && (v >> (4 * k)) == 16'h0) code = 7'h7F;
`endif
      res = res | ({21'b0, code} << (7 * k));
    end
    return res;
  endfunction

  function automatic logic [27:0] exp_disp();
    if (m_mode == 1) return anim_pattern(m_frame);
    if (m_mode == 2) return show_pattern(m_shown);
    return 28'hFFFFFFF;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'(m_mode == 2));
    checkOutput({tag, "_step_tick"}, 32'(step_tick), 32'(m_mode == 1 && m_phase == P - 1));
    checkOutput({tag, "_frame_idx"}, 32'(frame_idx), 32'(m_frame));
    checkOutput({tag, "_val_ack"}, 32'(val_ack), 32'(m_ack));
    checkOutput({tag, "_disp"}, {4'h0, disp_3, disp_2, disp_1, disp_0}, {4'h0, exp_disp()});
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_phase = 0;
    m_frame = 0;
    m_left  = 0;
    m_shown = 16'h0;
    m_ack   = 0;
  endtask

  task automatic model_accept();
    m_mode  = 2;
    m_shown = val_data;
    m_left  = P * H;
    m_phase = 0;
    m_ack   = 1;
    sb_q.push_back(val_data);
  endtask

  // One rising edge of the behavioural model, using the inputs now applied.
  task automatic model_step();
    m_ack = 0;
    case (m_mode)
      0: begin
        if (val_req) model_accept();
        else if (anim_en) begin
          m_mode  = 1;
          m_phase = 0;
        end
      end
      1: begin
        if (m_phase == P - 1) m_frame = (m_frame + 1) % 12;
        if (val_req) model_accept();
        else if (!anim_en) begin
          m_mode  = 0;
          m_phase = 0;
          m_frame = 0;
        end else m_phase = (m_phase + 1) % P;
      end
      default: begin
        m_left  = m_left - 1;
        m_phase = (m_phase + 1) % P;
        if (m_left == 0) begin
          m_mode  = anim_en ? 1 : 0;
          m_phase = 0;
        end
      end
    endcase
  endtask

  task automatic new_request();
    logic [15:0] d;
    d = 16'($urandom);
    case ($urandom % 4)
      0: d = d & 16'h00FF;
      1: d = d & 16'h000F;
      2: d = d & 16'h0F0F;
      default: d = d;
    endcase
    if (n_req == 0) d = 16'h1A3F;
    if (n_req == 1) d = 16'h0042;
    n_req++;
    val_req     = 1'b1;
    val_data    = d;
    req_pending = 1;
  endtask

  task automatic applyStimulus(input int cyc);
    if (m_ack) begin
      req_pending = 0;
      val_req     = 1'b0;
      if ($urandom % 4 == 0) new_request();
    end else if (!req_pending && cyc >= 60 && $urandom % 20 == 0) begin
      new_request();
    end
    if (cyc < 60) anim_en = 1'b1;
    else if ($urandom % 40 == 0) anim_en = ~anim_en;
  endtask

  // Scoreboard monitor: every ack must match the oldest accepted request.
  initial begin
    logic [15:0] exp_v;
    forever begin
      @(posedge clk);
      #2;
      if (val_ack === 1'b1) begin
        if (sb_q.size() == 0) begin
          checkOutput("sb_unexpected_ack", 32'(sb_q.size()), 32'd1);
        end else begin
          exp_v = sb_q.pop_front();
          checkOutput("sb_disp", {4'h0, disp_3, disp_2, disp_1, disp_0}, {4'h0, show_pattern(exp_v)});
          checkOutput("sb_busy", 32'(busy), 32'd1);
        end
      end
    end
  end

  initial begin
    rst         = 1'b1;
    anim_en     = 1'b0;
    val_req     = 1'b0;
    val_data    = 16'h0;
    req_pending = 0;
    model_reset();
    repeat (2) @(negedge clk);
    checkAll("reset");
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(cyc);
      @(posedge clk);
      model_step();
      #1;
      checkAll("cycle");
      if (!did_reset && cyc > 1500 && m_mode == 2 && !m_ack) begin
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        sb_q.delete();
        checkAll("async_reset");
        @(posedge clk);
        #1;
        checkAll("reset_hold");
        did_reset = 1;
      end
    end
    @(posedge clk);
    #3;
    checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);
    checkOutput("async_reset_exercised", 32'(did_reset), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
